// File: rtl/uart_fifo_link.sv
// UART link: TX FIFO feeding a serializer, deserializer feeding an RX FIFO.
// Sticky framing/overrun flags; all configuration is by parameter.
module uart_fifo_link #(
  parameter int DIVISOR   = 687,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [LW-1:0]        tx_level,
  output logic [LW-1:0]        rx_level,
  output logic                 tx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 clear_err,
  output logic                 txd,
  input  logic                 rxd,
  output logic [1:0]           tx_state,
  output logic [1:0]           rx_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0]   DIV_M1    = 16'(DIVISOR - 1);
  localparam logic [15:0]   HALF_M1   = 16'(DIVISOR / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL      = LW'(DEPTH);

  // Handshakes: a transfer happens on a clk edge where valid && ready; ready
  // depends only on registered state, and data is ignored when no transfer occurs.

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [DEPTH];
  logic [AW-1:0]        tx_wr_ptr, tx_rd_ptr;
  logic                 tx_push, tx_pop;
  logic [15:0]          tx_cnt;
  logic [3:0]           tx_bit;
  logic                 tx_stop_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_bit_end, tx_frame_end;

  assign tx_ready     = (tx_level != FULL);
  assign tx_push      = tx_valid && tx_ready;
  assign tx_bit_end   = (tx_cnt == DIV_M1);
  assign tx_frame_end = (tx_state == S_STOP) && tx_bit_end && (tx_stop_idx == LAST_STOP);
  assign tx_pop       = (tx_level != '0) && ((tx_state == S_IDLE) || tx_frame_end);
  assign tx_busy      = (tx_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + LW'(1);
        2'b01:   tx_level <= tx_level - LW'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  // ---------------- TX serializer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= S_IDLE;
      txd         <= 1'b1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd_ptr];
            tx_state <= S_START;
            txd      <= 1'b0;
            tx_cnt   <= '0;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_state <= S_DATA;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
              tx_state    <= S_STOP;
              tx_stop_idx <= 1'b0;
              txd         <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 4'd1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_stop_idx == LAST_STOP) begin
              // Chain straight into the next start bit when more data is queued.
              if (tx_pop) begin
                tx_shift <= tx_mem[tx_rd_ptr];
                tx_state <= S_START;
                txd      <= 1'b0;
              end else tx_state <= S_IDLE;
            end else tx_stop_idx <= 1'b1;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev;
  logic [15:0]          rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_stop_hit, rx_push, rx_pop, rx_full;
  logic [DATA_BITS-1:0] rx_mem [DEPTH];
  logic [AW-1:0]        rx_wr_ptr, rx_rd_ptr;

  assign rx_s        = rx_sync[1];
  assign rx_stop_hit = (rx_state == S_STOP) && (rx_cnt == DIV_M1);
  assign rx_full     = (rx_level == FULL);
  assign rx_valid    = (rx_level != '0);
  assign rx_pop      = rx_valid && rx_ready;
  assign rx_push     = rx_stop_hit && rx_s && (!rx_full || rx_pop);
  assign rx_data     = rx_mem[rx_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        S_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) rx_state <= S_STOP;
            else rx_bit <= rx_bit + 4'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: begin
          if (rx_stop_hit) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // A flag being set in the same cycle as clear_err stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (rx_stop_hit && !rx_s) rx_frame_err <= 1'b1;
      else if (clear_err)       rx_frame_err <= 1'b0;
      if (rx_stop_hit && rx_s && rx_full && !rx_pop) rx_overrun <= 1'b1;
      else if (clear_err)                            rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_link.sv
// Bench for uart_fifo_link: random words through a loopback checked against an
// expected-word queue, plus directed frame timing, overrun, glitch and reset cases.
module tb_uart_fifo_link;

  localparam int DIV        = 16;
  localparam int DB         = 8;
  localparam int SB         = 1;
  localparam int DEP        = 4;
  localparam int LW         = $clog2(DEP) + 1;
  localparam int FRAME_BITS = 1 + DB + SB;
  localparam int FRAME      = FRAME_BITS * DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic [DB-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic [LW-1:0] tx_level, rx_level;
  logic          tx_busy, rx_frame_err, rx_overrun, clear_err;
  logic          txd, rxd, loop_en, rxd_drv;
  logic [1:0]    tx_state, rx_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [DB-1:0] exp_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  uart_fifo_link #(.DIVISOR(DIV), .DATA_BITS(DB), .STOP_BITS(SB), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .tx_busy(tx_busy),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .clear_err(clear_err),
    .txd(txd), .rxd(rxd), .tx_state(tx_state), .rx_state(rx_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation still running after 50000 cycles, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Expected line level during bit slot b of a frame: start, data LSB first, stops.
  function automatic logic line_bit(input logic [DB-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DB) return d[b-1];
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [DB-1:0] d);
    bit ok = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 4000; i++) begin
      if (tx_ready) begin
        ok = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    tx_data  = DB'($urandom);
    if (!ok) begin
      total_cnt++;
      $display("FAIL push_timeout: tx_ready stayed %b, required 1", tx_ready);
    end
  endtask

  task automatic pop_word(output logic [DB-1:0] d, output logic v);
    v = rx_valid;
    d = rx_data;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget, output int n);
    n = 0;
    while (!(tx_busy === 1'b0 && tx_level === '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_rx_level(input int lvl, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rx_level === LW'(lvl)) break;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_val);
    for (int b = 0; b <= DB + 1; b++) begin
      rxd_drv = (b == DB + 1) ? stop_val : line_bit(d, b);
      tick(DIV);
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; loop_en = 1'b0; rxd_drv = 1'b1;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; clear_err = 1'b0;
    tick(3);
    total_cnt++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL reset_tx: txd=%b busy=%b ready=%b, required 1 0 1", txd, tx_busy, tx_ready);
    else pass_cnt++;
    total_cnt++;
    if (tx_level !== '0 || rx_level !== '0 || rx_valid !== 1'b0)
      $display("FAIL reset_levels: tx_level=%0d rx_level=%0d rx_valid=%b, required 0 0 0",
               tx_level, rx_level, rx_valid);
    else pass_cnt++;
    total_cnt++;
    if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0)
      $display("FAIL reset_flags: frame_err=%b overrun=%b, required 0 0", rx_frame_err, rx_overrun);
    else pass_cnt++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_tx_frame();
    logic [DB-1:0] words[2];
    int bad;
    logic e;
    words[0] = 8'hA5;
    words[1] = DB'($urandom);
    loop_en = 1'b0; rxd_drv = 1'b1;
    for (int w = 0; w < 2; w++) begin
      tx_valid = 1'b1; tx_data = words[w];
      @(negedge clk);
      tx_valid = 1'b0; tx_data = DB'($urandom);
      total_cnt++;
      if (txd !== 1'b1 || tx_level !== LW'(1))
        $display("FAIL tx_latency: txd=%b tx_level=%0d one cycle after push, required 1 1", txd, tx_level);
      else pass_cnt++;
      @(negedge clk);
      for (int b = 0; b < FRAME_BITS; b++) begin
        bad = 0;
        e = line_bit(words[w], b);
        for (int c = 0; c < DIV; c++) begin
          if (txd !== e || tx_busy !== 1'b1) bad++;
          @(negedge clk);
        end
        total_cnt++;
        if (bad != 0)
          $display("FAIL tx_bit%0d: word %h had %0d cycles off, required txd=%b busy=1 for %0d cycles",
                   b, words[w], bad, e, DIV);
        else pass_cnt++;
      end
      total_cnt++;
      if (tx_busy !== 1'b0 || txd !== 1'b1)
        $display("FAIL tx_done: busy=%b txd=%b after %0d cycles, required 0 1", tx_busy, txd, FRAME);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] words[3];
    logic [DB-1:0] d, e;
    logic v;
    int n;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      push_word(words[i]);
    end
    wait_tx_idle(4 * FRAME, n);
    // The first frame started one cycle before the last push completed.
    total_cnt++;
    if (n !== 3 * FRAME - 1)
      $display("FAIL b2b_gapless: tx idle after %0d cycles, required %0d", n, 3 * FRAME - 1);
    else pass_cnt++;
    wait_rx_level(3, 40);
    total_cnt++;
    if (rx_level !== LW'(3) || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0)
      $display("FAIL b2b_level: rx_level=%0d fe=%b ov=%b, required 3 0 0", rx_level, rx_frame_err, rx_overrun);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      pop_word(d, v);
      e = exp_q.pop_front();
      total_cnt++;
      if (v !== 1'b1 || d !== e)
        $display("FAIL b2b_word%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_loopback();
    logic [DB-1:0] w, d, e;
    logic v;
    int k, n;
    loop_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, DEP);
      for (int i = 0; i < k; i++) begin
        w = DB'($urandom);
        exp_q.push_back(w);
        push_word(w);
      end
      wait_tx_idle((k + 1) * FRAME, n);
      wait_rx_level(k, 40);
      total_cnt++;
      if (rx_level !== LW'(k))
        $display("FAIL rand_level: round %0d rx_level=%0d, required %0d", r, rx_level, k);
      else pass_cnt++;
      for (int i = 0; i < k; i++) begin
        pop_word(d, v);
        e = exp_q.pop_front();
        total_cnt++;
        if (v !== 1'b1 || d !== e)
          $display("FAIL rand_word: round %0d idx %0d valid=%b data=%h, required 1 %h", r, i, v, d, e);
        else pass_cnt++;
      end
      tick($urandom_range(0, 30));
    end
    total_cnt++;
    if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0)
      $display("FAIL rand_flags: fe=%b ov=%b, required 0 0", rx_frame_err, rx_overrun);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [DB-1:0] w, d, e;
    logic v;
    int n;
    loop_en = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < DEP + 1; i++) begin
      w = DB'($urandom);
      if (i < DEP) exp_q.push_back(w);
      push_word(w);
    end
    wait_tx_idle((DEP + 2) * FRAME, n);
    tick(5);
    total_cnt++;
    if (rx_level !== LW'(DEP) || rx_overrun !== 1'b1 || rx_frame_err !== 1'b0)
      $display("FAIL overrun_set: rx_level=%0d ov=%b fe=%b, required %0d 1 0", rx_level, rx_overrun, rx_frame_err, DEP);
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== exp_q[0])
      $display("FAIL overrun_head: rx_data=%h, required %h", rx_data, exp_q[0]);
    else pass_cnt++;
    pulse_clear();
    total_cnt++;
    if (rx_overrun !== 1'b0 || rx_level !== LW'(DEP))
      $display("FAIL overrun_clear: ov=%b rx_level=%0d, required 0 %0d", rx_overrun, rx_level, DEP);
    else pass_cnt++;
    for (int i = 0; i < DEP; i++) begin
      pop_word(d, v);
      e = exp_q.pop_front();
      total_cnt++;
      if (v !== 1'b1 || d !== e)
        $display("FAIL overrun_word%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch_frame_err();
    logic [DB-1:0] d, got;
    logic v;
    loop_en = 1'b0; rxd_drv = 1'b1;
    tick(5);
    rxd_drv = 1'b0;
    tick(4);
    rxd_drv = 1'b1;
    tick(40);
    total_cnt++;
    if (rx_level !== '0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0)
      $display("FAIL glitch: rx_level=%0d fe=%b ov=%b, required 0 0 0", rx_level, rx_frame_err, rx_overrun);
    else pass_cnt++;
    send_frame(DB'($urandom), 1'b0);
    total_cnt++;
    if (rx_frame_err !== 1'b1 || rx_level !== '0)
      $display("FAIL frame_err: fe=%b rx_level=%0d, required 1 0", rx_frame_err, rx_level);
    else pass_cnt++;
    tick(2 * DIV);
    rxd_drv = 1'b1;
    tick(DIV);
    total_cnt++;
    if (rx_level !== '0)
      $display("FAIL frame_err_hold: rx_level=%0d while line stayed low, required 0", rx_level);
    else pass_cnt++;
    pulse_clear();
    total_cnt++;
    if (rx_frame_err !== 1'b0)
      $display("FAIL frame_err_clear: fe=%b, required 0", rx_frame_err);
    else pass_cnt++;
    d = DB'($urandom);
    send_frame(d, 1'b1);
    tick(4);
    pop_word(got, v);
    total_cnt++;
    if (v !== 1'b1 || got !== d)
      $display("FAIL recover_word: valid=%b data=%h, required 1 %h", v, got, d);
    else pass_cnt++;
  endtask

  task automatic test_tx_full_reset();
    loop_en = 1'b0; rxd_drv = 1'b1;
    // One word is taken by the serializer right away, so DEPTH+1 pushes fill the FIFO.
    for (int i = 0; i < DEP + 1; i++) push_word(DB'($urandom));
    total_cnt++;
    if (tx_level !== LW'(DEP) || tx_ready !== 1'b0)
      $display("FAIL tx_full: tx_level=%0d ready=%b, required %0d 0", tx_level, tx_ready, DEP);
    else pass_cnt++;
    tx_valid = 1'b1; tx_data = DB'($urandom);
    @(negedge clk);
    tx_valid = 1'b0;
    total_cnt++;
    if (tx_level !== LW'(DEP))
      $display("FAIL tx_full_reject: tx_level=%0d, required %0d", tx_level, DEP);
    else pass_cnt++;
    tick(40);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (txd !== 1'b1 || tx_level !== '0 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL midframe_reset: txd=%b level=%0d busy=%b ready=%b, required 1 0 0 1",
               txd, tx_level, tx_busy, tx_ready);
    else pass_cnt++;
    tick(3);
    reset = 1'b0;
    tick(30);
    total_cnt++;
    if (tx_busy !== 1'b0 || txd !== 1'b1)
      $display("FAIL reset_discard: busy=%b txd=%b, required 0 1", tx_busy, txd);
    else pass_cnt++;
    tx_valid = 1'b1; tx_data = DB'($urandom);
    @(negedge clk);
    tx_valid = 1'b0;
    total_cnt++;
    if (txd !== 1'b1)
      $display("FAIL post_reset_latency: txd=%b one cycle after push, required 1", txd);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (txd !== 1'b0 || tx_busy !== 1'b1)
      $display("FAIL post_reset_start: txd=%b busy=%b, required 0 1", txd, tx_busy);
    else pass_cnt++;
    tick(FRAME + 5);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_random_loopback();
    test_overrun();
    test_glitch_frame_err();
    test_tx_full_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
